wishbone_arbiter: RTL and testbench

Round-robin arbiter that shares one Wishbone peripheral bus (8-bit data, classic single-cycle strobe/ack) between `pN` controllers, e.g. the SPI-to-Wishbone bridge and an on-chip sequencer. It sits between the controllers and the address decoder that feeds the peripherals (RGB LED, debug, charlieplex). It grants one controller at a time, forwards its cycle, and returns ack and read data only to that controller. A watchdog terminates cycles that no peripheral acknowledges.

---
 rtl/wishbone_arbiter_pkg.sv | 12 +
 rtl/wishbone_arbiter_round_robin_pick.sv | 35 +++
 rtl/wishbone_arbiter.sv | 125 ++++++++++++
 tb/tb_wishbone_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_arbiter_pkg.sv
// Shared definitions for the Wishbone arbiter slice: FSM states and the
// read data returned to a controller whose cycle was cut off by the watchdog.
package pkg_wishbone;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_RDAT = 8'hFF;

endpackage

// File: rtl/wishbone_arbiter_round_robin_pick.sv
// Combinational round-robin selector: first set request bit at or after ptr,
// wrapping circularly. Reusable by other arbiters and decoders.
module round_robin_pick #(
    parameter int pN = 2
) (
    input  logic [pN-1:0]         req,
    input  logic [$clog2(pN)-1:0] ptr,
    output logic [pN-1:0]         win,
    output logic                  any,
    output logic [$clog2(pN)-1:0] win_idx
);

    localparam int PW = $clog2(pN);

    int            w_idx;
    logic [PW-1:0] w_sel;

    always_comb begin
        win     = '0;
        any     = 1'b0;
        win_idx = '0;
        w_idx   = 0;
        w_sel   = '0;
        for (int k = 0; k < pN; k++) begin
            w_idx = (int'(ptr) + k) % pN;
            w_sel = PW'(w_idx);
            if (!any && req[w_sel]) begin
                win[w_sel] = 1'b1;
                any        = 1'b1;
                win_idx    = w_sel;
            end
        end
    end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one 8-bit classic Wishbone peripheral bus between
// pN controllers, with a watchdog that terminates unacknowledged cycles.
module wishbone_arbiter
    import pkg_wishbone::*;
#(
    parameter int pN       = 2,
    parameter int pAddrLen = 4,
    parameter int pTimeout = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [pN-1:0]          ctrl_stb,
    input  logic [pN-1:0]          ctrl_we,
    input  logic [pN*pAddrLen-1:0] ctrl_adr,
    input  logic [pN*8-1:0]        ctrl_dat,
    output logic [pN-1:0]          ctrl_ack,
    output logic [7:0]             ctrl_rdat,
    output logic                   peri_stb,
    output logic                   peri_we,
    output logic [pAddrLen-1:0]    peri_adr,
    output logic [7:0]             peri_dat,
    input  logic                   peri_ack,
    input  logic [7:0]             peri_rdat,
    output logic [pN-1:0]          grant,
    output logic                   timeout,
    output state_t                 dbg_state
);

    localparam int PW = $clog2(pN);
    localparam int CW = (pTimeout > 0) ? $clog2(pTimeout + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((pTimeout > 0) ? pTimeout - 1 : 0);

    state_t        r_state;
    logic [pN-1:0] r_grant;
    logic [PW-1:0] r_owner;
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;

    logic [pN-1:0]       w_win;
    logic                w_any;
    logic [PW-1:0]       w_win_idx;
    logic                w_busy;
    logic                w_own_stb;
    logic                w_own_we;
    logic [pAddrLen-1:0] w_own_adr;
    logic [7:0]          w_own_dat;
    logic                w_active;
    logic                w_expire;
    logic                w_ack;

    round_robin_pick #(.pN(pN)) u_pick (
        .req     (ctrl_stb),
        .ptr     (r_ptr),
        .win     (w_win),
        .any     (w_any),
        .win_idx (w_win_idx)
    );

    always_comb begin
        w_own_stb = 1'b0;
        w_own_we  = 1'b0;
        w_own_adr = '0;
        w_own_dat = '0;
        for (int i = 0; i < pN; i++) begin
            if (PW'(i) == r_owner) begin
                w_own_stb = ctrl_stb[i];
                w_own_we  = ctrl_we[i];
                w_own_adr = ctrl_adr[i*pAddrLen +: pAddrLen];
                w_own_dat = ctrl_dat[i*8 +: 8];
            end
        end

        w_busy   = (r_state == BUSY);
        // A dropped strobe is an abort: no ack and no watchdog pulse.
        w_active = w_busy && w_own_stb;
        w_expire = (pTimeout != 0) && w_active && (r_cnt == CNT_LAST) && !peri_ack;
        w_ack    = w_active && (peri_ack || w_expire);

        peri_stb  = w_active && !w_expire;
        peri_we   = w_busy && w_own_we;
        peri_adr  = w_busy ? w_own_adr : '0;
        peri_dat  = w_busy ? w_own_dat : '0;
        ctrl_ack  = w_ack ? r_grant : '0;
        ctrl_rdat = !w_ack ? 8'h00 : (w_expire ? TIMEOUT_RDAT : peri_rdat);
        timeout   = w_expire;
    end

    assign grant     = r_grant;
    assign dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= BUSY;
                        r_grant <= w_win;
                        r_owner <= w_win_idx;
                        r_ptr   <= (w_win_idx == PW'(pN - 1)) ? '0 : w_win_idx + PW'(1);
                        r_cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (!w_own_stb || w_ack) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                    end else if (pTimeout != 0) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Bench for wishbone_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_wishbone_arbiter;
    import pkg_wishbone::*;

    localparam int N = 2;
    localparam int A = 4;
    localparam int T = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // valid/ready: a controller holds stb (with we/adr/dat) until it sees its
    // ctrl_ack bit or abandons the cycle; peri_ack completes a cycle the same clock.
    logic [N-1:0]   ctrl_stb = '0;
    logic [N-1:0]   ctrl_we = '0;
    logic [N*A-1:0] ctrl_adr = '0;
    logic [N*8-1:0] ctrl_dat = '0;
    logic [N-1:0]   ctrl_ack;
    logic [7:0]     ctrl_rdat;
    logic           peri_stb;
    logic           peri_we;
    logic [A-1:0]   peri_adr;
    logic [7:0]     peri_dat;
    logic           peri_ack = 1'b0;
    logic [7:0]     peri_rdat = '0;
    logic [N-1:0]   grant;
    logic           timeout;
    state_t         dbg_state;

    wishbone_arbiter #(.pN(N), .pAddrLen(A), .pTimeout(T)) dut (
        .clk(clk), .rst(rst),
        .ctrl_stb(ctrl_stb), .ctrl_we(ctrl_we), .ctrl_adr(ctrl_adr), .ctrl_dat(ctrl_dat),
        .ctrl_ack(ctrl_ack), .ctrl_rdat(ctrl_rdat),
        .peri_stb(peri_stb), .peri_we(peri_we), .peri_adr(peri_adr), .peri_dat(peri_dat),
        .peri_ack(peri_ack), .peri_rdat(peri_rdat),
        .grant(grant), .timeout(timeout), .dbg_state(dbg_state)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // model: who owns the bus (-1 = nobody), where the search starts next,
    // and how many cycles the owner has held the bus including this one
    int m_owner = -1;
    int m_ptr   = 0;
    int m_age   = 0;

    // scoreboard of winners in grant order
    logic [N-1:0] exp_q[$];

    logic [N-1:0] obs_grant, obs_ack;
    logic         obs_stb, obs_to;
    logic [7:0]   obs_rdat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare all outputs with the model mid-cycle, then advance the model.
    task automatic step();
        logic [N-1:0] e_grant, e_ack;
        logic         e_stb, e_we, e_to, expire, acked;
        logic [A-1:0] e_adr;
        logic [7:0]   e_dat, e_rdat;
        @(negedge clk);
        e_grant = '0; e_ack = '0; e_stb = 1'b0; e_we = 1'b0; e_to = 1'b0;
        e_adr = '0; e_dat = '0; e_rdat = '0; expire = 1'b0; acked = 1'b0;
        if (m_owner >= 0) begin
            e_grant = N'(1 << m_owner);
            e_we    = ctrl_we[m_owner];
            e_adr   = ctrl_adr[m_owner*A +: A];
            e_dat   = ctrl_dat[m_owner*8 +: 8];
            if (ctrl_stb[m_owner]) begin
                expire = (m_age == T) && !peri_ack;
                acked  = peri_ack || expire;
                e_stb  = !expire;
                e_to   = expire;
                e_ack  = acked ? e_grant : '0;
                e_rdat = acked ? (expire ? 8'hFF : peri_rdat) : 8'h00;
            end
        end
        chk("grant", 32'(grant), 32'(e_grant));
        chk("peri_stb", 32'(peri_stb), 32'(e_stb));
        chk("peri_we", 32'(peri_we), 32'(e_we));
        chk("peri_adr", 32'(peri_adr), 32'(e_adr));
        chk("peri_dat", 32'(peri_dat), 32'(e_dat));
        chk("ctrl_ack", 32'(ctrl_ack), 32'(e_ack));
        chk("ctrl_rdat", 32'(ctrl_rdat), 32'(e_rdat));
        chk("timeout", 32'(timeout), 32'(e_to));
        obs_grant = grant; obs_ack = ctrl_ack; obs_stb = peri_stb;
        obs_to = timeout; obs_rdat = ctrl_rdat;
        @(posedge clk);
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_age = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && ctrl_stb[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            end
            if (m_owner >= 0) begin
                m_ptr = (m_owner + 1) % N;
                m_age = 1;
                exp_q.push_back(N'(1 << m_owner));
            end
        end else if (!ctrl_stb[m_owner] || acked) begin
            m_owner = -1;
        end else begin
            m_age++;
        end
        #1;
    endtask

    initial begin
        logic [N-1:0] first_win;
        // reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step();
        chk("reset_grant", 32'(obs_grant), 32'h0);
        rst = 1'b0;

        // single write from controller 0, ack in cycle 2
        ctrl_stb = 2'b01; ctrl_we = 2'b01; ctrl_adr = '0; ctrl_dat = 16'h00A5;
        step();
        step();
        chk("single_c1_grant", 32'(obs_grant), 32'h1);
        chk("single_c1_ack", 32'(obs_ack), 32'h0);
        peri_ack = 1'b1;
        step();
        chk("single_c2_ack", 32'(obs_ack), 32'h1);
        ctrl_stb = 2'b00; peri_ack = 1'b0;
        step();

        // contention from reset, zero-wait peripheral: 0,1,0,1
        rst = 1'b1; step(); rst = 1'b0;
        ctrl_stb = 2'b11; peri_ack = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (c % 2 == 1) chk("contend_grant", 32'(obs_grant), (c % 4 == 1) ? 32'h1 : 32'h2);
        end
        ctrl_stb = 2'b00; peri_ack = 1'b0;
        step();

        // read mux: controller 1 reads 8'h3C
        ctrl_stb = 2'b10; ctrl_we = 2'b00; peri_rdat = 8'h3C; peri_ack = 1'b1;
        step();
        step();
        chk("read_rdat", 32'(obs_rdat), 32'h3C);
        chk("read_ack", 32'(obs_ack), 32'h2);
        ctrl_stb = 2'b00; peri_ack = 1'b0;
        step();

        // watchdog with no ack, then ack landing in the expiry cycle
        ctrl_stb = 2'b01;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 4) begin
                chk("wd_timeout", 32'(obs_to), 32'h1);
                chk("wd_ack", 32'(obs_ack), 32'h1);
                chk("wd_rdat", 32'(obs_rdat), 32'hFF);
                chk("wd_stb", 32'(obs_stb), 32'h0);
            end
            if (c == 5) chk("wd_idle", 32'(obs_grant), 32'h0);
        end
        ctrl_stb = 2'b00; step(); step();
        ctrl_stb = 2'b01; peri_rdat = 8'h5A;
        for (int c = 0; c < 4; c++) step();
        peri_ack = 1'b1;
        step();
        chk("late_ack_timeout", 32'(obs_to), 32'h0);
        chk("late_ack_rdat", 32'(obs_rdat), 32'h5A);
        ctrl_stb = 2'b00; peri_ack = 1'b0;
        step();

        // abort by the owner
        ctrl_stb = 2'b01;
        step(); step();
        ctrl_stb = 2'b00;
        step();
        chk("abort_ack", 32'(obs_ack), 32'h0);
        step();
        chk("abort_grant", 32'(obs_grant), 32'h0);

        // reset while busy: pointer returns to controller 0
        ctrl_stb = 2'b10;
        step(); step();
        rst = 1'b1; ctrl_stb = 2'b11;
        step();
        rst = 1'b0;
        step();
        chk("rst_busy_grant", 32'(obs_grant), 32'h0);
        step();
        chk("rst_first_win", 32'(obs_grant), 32'h1);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 60) == 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) ctrl_stb[i] = ~ctrl_stb[i];
            ctrl_we   = N'($urandom);
            ctrl_adr  = (N*A)'($urandom);
            ctrl_dat  = (N*8)'($urandom);
            peri_ack  = ($urandom_range(0, 3) == 0);
            peri_rdat = 8'($urandom);
            step();
            if (obs_grant != '0 && obs_grant != dut.grant) begin
                // grant dropped this edge; nothing extra to track
            end
        end

        // every grant observed must match the model's order of winners
        ctrl_stb = '0; rst = 1'b0;
        step();
        first_win = (exp_q.size() > 0) ? exp_q[0] : '0;
        chk("queue_nonempty", 32'(exp_q.size() > 20), 32'h1);
        chk("queue_first", 32'(first_win), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
